// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and the SRAM slave FSM state type.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;
endpackage

// File: rtl/byte_en_ram.sv
// byte_en_ram: word-wide RAM with per-byte synchronous write enables and asynchronous read.
module byte_en_ram #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM responder with WAIT_STATES wait cycles per data phase.
// Define AHB_SRAM_ERR_EN to answer out-of-range, oversize and misaligned transfers with ERROR.
module ahb_sram_slave import ahb_pkg::*; #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_d, start;
  logic [3:0] cnt, cnt_d;
  logic [31:0] addr_q;
  logic write_q;
  logic [2:0] size_q;
  logic accept, bad;
  logic [3:0] we;
  logic [31:0] rdata;
  logic unused_bits;
  assign accept = HSEL & HREADY & HTRANS[1];
`ifdef AHB_SRAM_ERR_EN
  assign bad = (HADDR[31:2] >= 30'(DEPTH_WORDS)) | (HSIZE > HSIZE_WORD) |
               (HSIZE == HSIZE_HALF && HADDR[0]) | (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);
  assign HRESP = (state == S_ERR1 || state == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign bad = 1'b0;
  assign HRESP = HRESP_OKAY;
`endif
  assign start = bad ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_LAST;
  always_comb begin
    state_d = state;
    cnt_d = '0;
    unique case (state)
      S_WAIT: begin
        cnt_d = cnt + 4'd1;
        state_d = (cnt == 4'(WAIT_STATES - 1)) ? S_LAST : S_WAIT;
      end
      S_ERR1: state_d = S_ERR2;
      default: state_d = accept ? start : S_IDLE;
    endcase
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      state <= S_IDLE;
      cnt <= '0;
      addr_q <= '0;
      write_q <= 1'b0;
      size_q <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (accept) begin
        addr_q <= HADDR;
        write_q <= HWRITE;
        size_q <= HSIZE;
      end
    end
  // Little-endian lanes; oversize transfers fall through to a full-word write.
  assign we = (state == S_LAST && write_q) ?
              (size_q == HSIZE_BYTE ? 4'b0001 << addr_q[1:0] :
               size_q == HSIZE_HALF ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111) : 4'b0000;
  byte_en_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk(HCLK),
    .we(we),
    .addr(addr_q[AW+1:2]),
    .wdata(HWDATA),
    .rdata(rdata)
  );
  assign HREADYOUT = !(state == S_WAIT || state == S_ERR1);
  assign HRDATA = (state == S_LAST && !write_q) ? rdata : '0;
  assign unused_bits = ^{HTRANS[0], addr_q[31:AW+2]};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: scoreboard bench driving a zero-wait and a two-wait slave on separate buses.
module tb_ahb_sram_slave;
  import ahb_pkg::*;
`ifdef AHB_SRAM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  localparam int EW = ERR ? 1 : 2;
  typedef struct {
    logic [31:0] rdata;
    logic        chk;
    logic        resp;
    int          waits;
  } exp_t;
  logic clk = 0;
  logic rst;
  logic [1:0] sel, blk, rdyo, resp, hrdy;
  logic [31:0] haddr, hwdata;
  logic hwrite;
  logic [2:0] hsize;
  logic [1:0] htrans;
  logic [31:0] rdat [2];
  int checks = 0;
  int failures = 0;
  exp_t q0[$], q1[$];
  exp_t cur [2];
  bit act [2];
  int w [2];
  always #5 clk = ~clk;
  assign hrdy = rdyo & ~blk;
  ahb_sram_slave #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[0]), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
    .HTRANS(htrans), .HREADY(hrdy[0]), .HWDATA(hwdata), .HRDATA(rdat[0]),
    .HREADYOUT(rdyo[0]), .HRESP(resp[0]));
  ahb_sram_slave #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u1 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[1]), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
    .HTRANS(htrans), .HREADY(hrdy[1]), .HWDATA(hwdata), .HRDATA(rdat[1]),
    .HREADYOUT(rdyo[1]), .HRESP(resp[1]));

  task automatic check(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d got=%h expected=%h", nm, g, a, e);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        act[g] = 0;
        check("reset_ready", g, 32'(rdyo[g]), 32'd1);
        check("reset_resp", g, 32'(resp[g]), 32'd0);
        check("reset_rdata", g, rdat[g], 32'd0);
      end else begin
        if (act[g]) begin
          if (!rdyo[g]) begin
            w[g]++;
            check("wait_resp", g, 32'(resp[g]), 32'(cur[g].resp));
            check("wait_rdata", g, rdat[g], 32'd0);
          end else begin
            check("wait_cycles", g, 32'(w[g]), 32'(cur[g].waits));
            check("resp", g, 32'(resp[g]), 32'(cur[g].resp));
            if (cur[g].chk) check("rdata", g, rdat[g], cur[g].rdata);
            act[g] = 0;
          end
        end else begin
          check("idle_ready", g, 32'(rdyo[g]), 32'd1);
          check("idle_resp", g, 32'(resp[g]), 32'd0);
          check("idle_rdata", g, rdat[g], 32'd0);
        end
        if (sel[g] && hrdy[g] && htrans[1]) begin
          if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_transfer dut%0d got=accept expected=none", g);
          end else if (g == 0) cur[g] = q0.pop_front();
          else cur[g] = q1.pop_front();
          act[g] = 1;
          w[g] = 0;
        end
      end
    end
  end

  task automatic issue(input int d, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                       input logic [31:0] data, input logic rsp, input int nw);
    exp_t e;
    bit ok;
    int n = 0;
    e.rdata = data;
    e.chk = !wr;
    e.resp = rsp;
    e.waits = nw;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    sel = (d == 0) ? 2'b01 : 2'b10;
    haddr = a;
    hwrite = wr;
    hsize = sz;
    htrans = HTRANS_NONSEQ;
    do begin
      @(negedge clk);
      ok = hrdy[d];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 40);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut%0d got=stalled expected=ready", d);
    end
    hwdata = data;
  endtask

  task automatic bus_idle(input int d);
    bit ok;
    int n = 0;
    htrans = HTRANS_IDLE;
    do begin
      @(negedge clk);
      ok = hrdy[d];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 40);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout dut%0d got=stalled expected=ready", d);
    end
    sel = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; sel = 0; blk = 0; haddr = 0; hwrite = 0; hsize = 0; htrans = HTRANS_IDLE; hwdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    issue(0, 32'h10, 1, HSIZE_WORD, 32'hDEADBEEF, 0, 0);
    issue(0, 32'h10, 0, HSIZE_WORD, 32'hDEADBEEF, 0, 0);
    issue(0, 32'h10, 1, HSIZE_WORD, 32'h11223344, 0, 0);
    issue(0, 32'h13, 1, HSIZE_BYTE, 32'hAA000000, 0, 0);
    issue(0, 32'h10, 0, HSIZE_WORD, 32'hAA223344, 0, 0);
    issue(0, 32'h10, 1, HSIZE_HALF, 32'h00005566, 0, 0);
    issue(0, 32'h10, 0, HSIZE_WORD, 32'hAA225566, 0, 0);
    issue(0, 32'h12, 1, HSIZE_HALF, 32'h77880000, 0, 0);
    issue(0, 32'h11, 1, HSIZE_BYTE, 32'h0000CC00, 0, 0);
    issue(0, 32'h10, 0, HSIZE_WORD, 32'h7788CC66, 0, 0);
    bus_idle(0);
    sel = 2'b01; htrans = HTRANS_IDLE; hwrite = 1; haddr = 32'h10; hsize = HSIZE_WORD; hwdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1 htrans = HTRANS_BUSY;
    repeat (2) @(posedge clk);
    #1 sel = 2'b00; htrans = HTRANS_NONSEQ;
    repeat (2) @(posedge clk);
    #1 sel = 2'b01; blk = 2'b01;
    repeat (2) @(posedge clk);
    #1 htrans = HTRANS_IDLE; blk = 2'b00; sel = 2'b00;
    @(posedge clk);
    #1;
    issue(0, 32'h10, 0, HSIZE_WORD, 32'h7788CC66, 0, 0);
    bus_idle(0);
    issue(1, 32'h0, 1, HSIZE_WORD, 32'h01020304, 0, 2);
    issue(1, 32'h0, 0, HSIZE_WORD, 32'h01020304, 0, 2);
    issue(1, 32'h20, 1, HSIZE_WORD, 32'hA5A5A5A5, 0, 2);
    issue(1, 32'h20, 0, HSIZE_WORD, 32'hA5A5A5A5, 0, 2);
    bus_idle(1);
    issue(1, 32'h0, 1, HSIZE_WORD, 32'hFFFFFFFF, 0, 2);
    htrans = HTRANS_IDLE; sel = 2'b00; rst = 1;
    @(posedge clk);
    #1 rst = 0;
    issue(1, 32'h0, 0, HSIZE_WORD, 32'h01020304, 0, 2);
    issue(1, 32'h400, 1, HSIZE_WORD, 32'hCAFEF00D, ERR, EW);
    issue(1, 32'h2, 0, HSIZE_WORD, ERR ? 32'h0 : 32'hCAFEF00D, ERR, EW);
    issue(1, 32'h20, 0, 3'd3, ERR ? 32'h0 : 32'hA5A5A5A5, ERR, EW);
    issue(1, 32'h0, 0, HSIZE_WORD, ERR ? 32'h01020304 : 32'hCAFEF00D, 0, 2);
    bus_idle(1);
    repeat (3) @(posedge clk);
    check("q_drained", 0, 32'(q0.size()), 32'd0);
    check("q_drained", 1, 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite responder that services transfers from the bus master and returns read data toward the read-data mux. It is one slave slot behind the address decoder: it drives HRDATA, HREADYOUT and HRESP for a word-organised, byte-writable SRAM with a parameterised number of wait states. It handles the address/data phase overlap of the protocol, so back-to-back transfers run without bubbles when WAIT_STATES is 0.

## Interface
- DEPTH_WORDS, 256: SRAM depth in 32-bit words, power of two.
- WAIT_STATES, 1: HREADYOUT-low cycles inserted in every data phase, 0..15.
- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address, address phase.
- HWRITE  in  1  1 = write, address phase.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word.
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
- HREADY  in  1  bus-wide ready, the mux output of all HREADYOUTs.
- HWDATA  in  32  write data, data phase.
- HRDATA  out  32  read data to the mux.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- A transfer is accepted on a rising edge where HSEL & HREADY & HTRANS[1] are all high. On acceptance HADDR, HWRITE and HSIZE are registered into addr_q, write_q and size_q.
- IDLE/BUSY transfers, or HSEL low: no data phase is started. The slave responds OKAY with zero wait states.
- FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
  - IDLE → WAIT on acceptance when WAIT_STATES > 0; otherwise IDLE → LAST.
  - WAIT counts WAIT_STATES cycles with HREADYOUT = 0, then moves to LAST.
  - LAST has HREADYOUT = 1. On exit it goes to WAIT, LAST or ERR1 if a new transfer is accepted in the same cycle; otherwise it goes to IDLE.
- Write: HWDATA is sampled in the LAST cycle and committed at the end of that cycle.
  - Byte lanes are little-endian and selected by addr_q[1:0] and size_q.
  - Byte writes use lane addr_q[1:0]. Halfword writes use lanes {addr_q[1],0}+1 and {addr_q[1],0}.
- Read: in LAST, HRDATA = mem[addr_q word index]. HRDATA is 0 in all other cycles.
  - The array read is asynchronous from the registered address. A read that immediately follows a write to the same word therefore returns the new data.
- A word index ≥ DEPTH_WORDS aliases modulo DEPTH_WORDS unless the error feature is enabled (see Configuration).
- Reset mid-transfer: the FSM returns to IDLE and the wait counter clears. An in-flight write is discarded. Memory contents are not cleared.

## Timing
- Reset values: HREADYOUT = 1, HRESP = 0, HRDATA = 0, FSM = IDLE, addr_q = 0, write_q = 0, size_q = 0.
- Data-phase length is WAIT_STATES + 1 cycles for OKAY transfers and exactly 2 cycles for ERROR transfers.
- With WAIT_STATES = 0, consecutive transfers complete one per cycle.
- When HREADY is low because another slave is stalling, new acceptance is blocked. An address presented while HREADY is low is not captured.

## Configuration
- AHB_SRAM_ERR_EN defined: the following transfers take the ERR1 → ERR2 path instead of WAIT/LAST:
  - word index ≥ DEPTH_WORDS;
  - HSIZE > 2;
  - misaligned address (halfword with addr[0] set; word with addr[1:0] ≠ 0).
- ERR1 drives HREADYOUT = 0, HRESP = 1. ERR2 drives HREADYOUT = 1, HRESP = 1. No memory write occurs and HRDATA = 0. The wait-state count is not applied.
- AHB_SRAM_ERR_EN undefined: HRESP is tied 0. Misaligned addresses are aligned down, HSIZE > 2 is treated as word, and out-of-range indices alias.

## Structure
- Package ahb_pkg holds:
  - HTRANS encodings (IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3);
  - HSIZE encodings;
  - HRESP OKAY/ERROR constants;
  - the FSM state enum.
- Sub-module byte_en_ram: DEPTH_WORDS × 32 array with 4-bit byte-enable synchronous write and asynchronous read. The top level keeps the FSM, wait counter, phase registers and lane decode.

## Test plan
- WAIT_STATES = 0: word write 0xDEADBEEF @0x10, then read @0x10 back-to-back → HREADYOUT stays 1 and HRDATA = 0xDEADBEEF in the read's data phase.
- WAIT_STATES = 2: read @0x0 → HREADYOUT is 0 for 2 cycles, then 1 with data; HRESP = 0 throughout.
- Byte write 0xAA @0x13 onto word 0x11223344 @0x10 → a later read returns 0xAA223344. Halfword write 0x5566 @0x10 → a later read returns 0xAA225566.
- HRESET asserted during a WAIT cycle of a write → next cycle HREADYOUT = 1, HRESP = 0, HRDATA = 0, and the target word is unchanged.
- AHB_SRAM_ERR_EN, DEPTH_WORDS = 256: write @0x400 → ERR1 (HREADYOUT = 0, HRESP = 1), then ERR2 (HREADYOUT = 1, HRESP = 1); word 0 is unchanged.
- HTRANS = IDLE with HSEL = 1, and separately HSEL = 0 with NONSEQ → no data phase, HREADYOUT stays 1, no write occurs.
